// File: rtl/energy_step_scheduler.sv
// energy_step_scheduler
//   Runs one energy-evaluation pass of the energy datapath. It latches the
//   target, pulses an accumulator clear, then steps the spin index through
//   fetch beats of PARALLELISM spins under a valid/ready handshake. When the
//   datapath reports its result, it pulses done.
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   en_i                     enable; low freezes state/index/target
//   abort_i                  sync abort to IDLE, highest priority
//   cfg_valid_i/_last_idx_i  target load (IDLE only), last spin index inclusive
//   start_i/start_ready_o    start handshake
//   acc_clear_o              one-cycle accumulator clear
//   fetch_valid_o/ready_i    fetch beat handshake
//   fetch_idx_o/fetch_last_o first spin index of beat / final beat flag
//   acc_done_i               datapath result valid pulse
//   busy_o, done_o, err_o    status, pass-complete pulse, sticky protocol error
module energy_step_scheduler #(
  parameter int unsigned COUNTER_BITWIDTH = 8,
  parameter int unsigned PARALLELISM      = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        en_i,
  input  logic                        abort_i,
  input  logic                        cfg_valid_i,
  input  logic [COUNTER_BITWIDTH-1:0] cfg_last_idx_i,
  input  logic                        start_i,
  output logic                        start_ready_o,
  output logic                        acc_clear_o,
  output logic                        fetch_valid_o,
  input  logic                        fetch_ready_i,
  output logic [COUNTER_BITWIDTH-1:0] fetch_idx_o,
  output logic                        fetch_last_o,
  input  logic                        acc_done_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o
);

  localparam int unsigned WX = COUNTER_BITWIDTH + 1;

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, DONE} state_t;

  state_t                      state, state_next;
  logic [COUNTER_BITWIDTH-1:0] index, index_next;
  logic [COUNTER_BITWIDTH-1:0] target;
  logic                        err;
  logic                        handshake;
  logic                        last;

  assign start_ready_o = en_i && (state == IDLE);
  assign handshake     = start_i && start_ready_o;

  // One extra bit so index + PARALLELISM cannot wrap below the target.
  assign last = ({1'b0, index} + WX'(PARALLELISM)) > {1'b0, target};

  assign fetch_idx_o  = index;
  assign fetch_last_o = (state == FETCH) && last;
  assign busy_o       = (state != IDLE);
  assign err_o        = err;

  always_comb begin
    state_next    = state;
    index_next    = index;
    acc_clear_o   = 1'b0;
    fetch_valid_o = 1'b0;
    done_o        = 1'b0;
    case (state)
      IDLE: begin
        if (handshake) begin
          state_next = CLEAR;
          index_next = '0;
        end
      end
      CLEAR: begin
        acc_clear_o = en_i;
        if (en_i) state_next = FETCH;
      end
      FETCH: begin
        fetch_valid_o = en_i;
        if (en_i && fetch_ready_i) begin
          if (last) state_next = DRAIN;
          else      index_next = index + COUNTER_BITWIDTH'(PARALLELISM);
        end
      end
      DRAIN: begin
        if (en_i && acc_done_i) state_next = DONE;
      end
      DONE: begin
        done_o = en_i;
        if (en_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (abort_i) begin
      state_next = IDLE;
      index_next = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      index  <= '0;
      target <= '1;
      err    <= 1'b0;
    end else begin
      state <= state_next;
      index <= index_next;
      if (cfg_valid_i && en_i && (state == IDLE))
        target <= cfg_last_idx_i;
      if (abort_i || handshake)
        err <= 1'b0;
      else if (acc_done_i && ((state == IDLE) || (state == CLEAR) || (state == FETCH)))
        err <= 1'b1;
    end
  end

endmodule
